// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divide sequencer.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } div_state_t;

    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = 5;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on the {rem, quo} shift pair.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // A WIDTH+1-bit trial is enough: rem < divisor, so the MSB is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (trial[WIDTH] == 1'b0) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Iterative DIV/DIVU sequencer with pipeline stall request and one-cycle done window.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations from PREP.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    div_state_t           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 sgn_q, sgn_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     step_rem;
    logic [WIDTH-1:0]     step_quo;

    // Two's-complement negate; the most negative value maps to itself, read as unsigned.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        sgn_d     = sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        stall_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    stall_o   = 1'b1;
                    state_d   = PREP;
                    quo_d     = dividend_i;
                    dvs_d     = divisor_i;
                    sgn_d     = signed_i;
                    neg_quo_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                    neg_rem_d = signed_i & dividend_i[WIDTH-1];
                end
            end
            PREP: begin
                stall_o = 1'b1;
                rem_d   = '0;
                cnt_d   = '0;
                quo_d   = cond_neg(quo_q, sgn_q & quo_q[WIDTH-1]);
                dvs_d   = cond_neg(dvs_q, sgn_q & dvs_q[WIDTH-1]);
                state_d = RUN;
`ifdef DIV_ZERO_FAST_EN
                // quo_q still holds the raw dividend here, which is what hi reports.
                if (dvs_q == '0) begin
                    lo_d    = '1;
                    hi_d    = quo_q;
                    state_d = DONE;
                end
`endif
            end
            RUN: begin
                stall_o = 1'b1;
                rem_d   = step_rem;
                quo_d   = step_quo;
                cnt_d   = cnt_q + DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) state_d = FIX;
            end
            FIX: begin
                stall_o = 1'b1;
                lo_d    = cond_neg(quo_q, neg_quo_q);
                hi_d    = cond_neg(rem_q, neg_rem_q);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A flush discards the operation and any result it was about to write.
        if (cancel_i) begin
            state_d = IDLE;
            lo_d    = lo_q;
            hi_d    = hi_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        dvs_q     <= dvs_d;
        sgn_q     <= sgn_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign lo_o   = lo_q;
    assign hi_o   = hi_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: scoreboard of expected {lo, hi} per issued divide.
module tb_div_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        cancel_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] lo_o;
    logic [31:0] hi_o;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb_q[$];
    logic [31:0] last_lo = 32'h0;
    logic [31:0] last_hi = 32'h0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 35;
`endif

    div_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .cancel_i   (cancel_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .lo_o       (lo_o),
        .hi_o       (hi_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int lat, input logic [31:0] elo, input logic [31:0] ehi,
                           input string nm);
        logic [63:0] exp_v;
        bit          seen;
        bit          stall_bad;
        sb_q.push_back({elo, ehi});
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL %s issue_stall got=%b want=1", nm, stall_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        seen = 0; stall_bad = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (stall_o !== ((k < lat) ? 1'b1 : 1'b0)) stall_bad = 1;
            if (done_o === 1'b1) begin
                seen = 1;
                exp_v = sb_q.pop_front();
                checks++;
                if (k != lat) begin
                    errors++; $display("FAIL %s done_cycle got=%0d want=%0d", nm, k, lat);
                end
                checks++;
                if (lo_o !== exp_v[63:32]) begin
                    errors++; $display("FAIL %s lo got=%h want=%h", nm, lo_o, exp_v[63:32]);
                end
                checks++;
                if (hi_o !== exp_v[31:0]) begin
                    errors++; $display("FAIL %s hi got=%h want=%h", nm, hi_o, exp_v[31:0]);
                end
                last_lo = exp_v[63:32];
                last_hi = exp_v[31:0];
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s done_timeout got=none want=cycle %0d", nm, lat);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        checks++;
        if (stall_bad) begin
            errors++; $display("FAIL %s stall_window got=wrong want=high cycles 0..%0d", nm, lat - 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall_o, busy_o, done_o} !== 3'b000 || lo_o !== 32'h0 || hi_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b%b %h %h want=000 0 0", stall_o, busy_o, done_o, lo_o, hi_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        run_div(32'd100, 32'd7, 1'b0, 35, 32'd14, 32'd2, "u100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 35, 32'h7FFF_FFFC, 32'd1, "u_m7_2");
    endtask

    task automatic test_signed();
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 35, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "s_m7_2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 35, 32'h8000_0000, 32'h0, "s_overflow");
    endtask

    task automatic test_div_zero();
        run_div(32'd5, 32'd0, 1'b0, ZERO_LAT, 32'hFFFF_FFFF, 32'd5, "u5_0");
        run_div(32'd5, 32'd0, 1'b1, ZERO_LAT, 32'hFFFF_FFFF, 32'd5, "s5_0");
`ifdef DIV_ZERO_FAST_EN
        run_div(32'hFFFF_FFFB, 32'd0, 1'b1, ZERO_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "s_m5_0");
`else
        run_div(32'hFFFF_FFFB, 32'd0, 1'b1, ZERO_LAT, 32'h0000_0001, 32'hFFFF_FFFB, "s_m5_0");
`endif
    endtask

    task automatic test_random();
        logic [31:0] a, b, elo, ehi;
        logic        s;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom >> $urandom_range(0, 28); s = 1'(i % 2);
            if (b == 32'h0) b = 32'd3;
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd9;
            if (s) begin
                elo = $signed(a) / $signed(b);
                ehi = $signed(a) % $signed(b);
            end else begin
                elo = a / b;
                ehi = a % b;
            end
            run_div(a, b, s, 35, elo, ehi, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_cancel();
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd77; divisor_i = 32'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL cancel_idle got=stall %b busy %b want=0 0", stall_o, busy_o);
        end
        begin
            bit done_seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done_o === 1'b1) done_seen = 1;
            end
            checks++;
            if (done_seen) begin
                errors++; $display("FAIL cancel_no_done got=done pulse want=none");
            end
        end
        checks++;
        if (lo_o !== last_lo || hi_o !== last_hi) begin
            errors++; $display("FAIL cancel_hold got=%h %h want=%h %h", lo_o, hi_o, last_lo, last_hi);
        end
    endtask

    task automatic test_start_cancel();
        @(posedge clk); #1;
        start_i = 1'b1; cancel_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd2;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL start_cancel_stall got=%b want=0", stall_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0; cancel_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL start_cancel_busy got=%b want=0", busy_o);
        end
    endtask

    task automatic test_back_to_back();
        run_div(32'd1000, 32'd33, 1'b0, 35, 32'd30, 32'd10, "b2b_first");
        run_div(32'hFFFF_FF9C, 32'd7, 1'b1, 35, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "b2b_second");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd500; divisor_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({stall_o, busy_o, done_o} !== 3'b000 || lo_o !== 32'h0 || hi_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got=%b%b%b %h %h want=000 0 0", stall_o, busy_o, done_o, lo_o, hi_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_div(32'd500, 32'd3, 1'b0, 35, 32'd166, 32'd2, "after_reset");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_random();
        test_cancel();
        test_start_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Iterative divide sequencer in the EX stage. Accepts a DIV/DIVU issued from the decode-to-execute pipeline register, stalls the pipeline while it runs a 32-step restoring division, and presents quotient/remainder to the HI/LO write path in a single-cycle `done` window. Flushes cancel it mid-operation. Its stall request feeds the hazard unit, which generates stallF/D/E/PC.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: a DIV/DIVU is valid in the E stage (MulDivE qualified by divide opcode).
- `signed_i`, in, 1: 1 = DIV, 0 = DIVU; sampled with `start_i`.
- `dividend_i`, in, WIDTH: rs value; sampled with `start_i`.
- `divisor_i`, in, WIDTH: rt value; sampled with `start_i`.
- `cancel_i`, in, 1: flushE/exception; aborts any operation in progress.
- `stall_o`, out, 1: stall request to the hazard unit.
- `busy_o`, out, 1: FSM not in IDLE.
- `done_o`, out, 1: single-cycle pulse; results valid.
- `lo_o`, out, WIDTH: quotient.
- `hi_o`, out, WIDTH: remainder.

## Operation
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - `start_i` & !`cancel_i` → PREP.
  - Latch the operands and the signed flag.
  - Record sign_q = sign(a)^sign(b) and sign_r = sign(a), signed mode only.
- PREP:
  - Take absolute values of the operands (signed mode only).
  - Clear the partial remainder.
  - Set the iteration counter to 0.
  - → RUN.
- RUN:
  - One restoring step per cycle: shift {rem, quo} left by 1, then trial-subtract the divisor.
  - If the result is non-negative, keep it and set quo LSB = 1.
  - Counter increments 0..31; at count 31 → FIX.
- FIX:
  - Signed mode: negate the quotient if sign_q, negate the remainder if sign_r.
  - Register the results into `lo_o`/`hi_o`.
  - → DONE.
- DONE: `done_o`=1 for one cycle; `start_i` is ignored (it is still the same instruction leaving E); → IDLE.
- Cancel: `cancel_i` in any state → IDLE next edge. No `done_o`; `lo_o`/`hi_o` keep their previous values.
- Arithmetic rules:
  - Trial subtract is WIDTH+1 bits wide.
  - abs(0x80000000) is treated as unsigned 0x80000000.
  - 0x80000000 / -1 (signed) → lo=0x80000000, hi=0.
- Divisor zero without the config macro: full sequence runs. Unsigned result is lo=0xFFFFFFFF, hi=dividend; signed result is sign-fixed accordingly. The architecture leaves this result undefined; it is not an error.
- Results hold until the next FIX or DONE write.

## Timing
- Reset values: state=IDLE; `stall_o`, `busy_o`, `done_o` = 0; `lo_o`, `hi_o` = 0; counter 0.
- `stall_o` = (IDLE & `start_i` & !`cancel_i`) | PREP | RUN | FIX. It is combinational so it asserts in the issue cycle. It is 0 in DONE so the instruction advances that cycle.
- Latency with start in cycle 0:
  - PREP in cycle 1.
  - RUN in cycles 2..33.
  - FIX in cycle 34.
  - DONE (`done_o`=1) in cycle 35.
  - 35 stall cycles in total.
- Back-to-back divides: a new start is accepted in the IDLE cycle following DONE.
- `cancel_i` and `start_i` in the same IDLE cycle: cancel wins and no operation starts.
- Reset mid-operation: immediate IDLE, outputs at reset values.

## Configuration
- `DIV_ZERO_FAST_EN` defined: PREP detects divisor==0 and goes directly to DONE.
  - `done_o` in cycle 2; stall only in cycles 0–1.
  - lo=0xFFFFFFFF, hi=dividend_i raw, in both signed and unsigned modes.
- `DIV_ZERO_FAST_EN` undefined: no zero detection; the 35-cycle path runs as above.

## Structure
- Shared package `div_pkg` holds:
  - state enum `div_state_t` (IDLE, PREP, RUN, FIX, DONE);
  - `DIV_ITERS` = 32;
  - `DIV_CNT_W` = 5.
- One sub-module `div_step`: combinational single restoring step. Inputs rem, quo, divisor; outputs next rem, next quo. Instantiated once in RUN.

## Test plan
- Unsigned 100/7, start at cycle 0 → `stall_o` high cycles 0–34, `done_o` at cycle 35, lo=14, hi=2.
- Signed -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; same operands unsigned → lo=0x7FFFFFFC, hi=1.
- Signed 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide 5 by 0, both builds:
  - macro undefined → done at cycle 35, lo=0xFFFFFFFF, hi=5;
  - macro defined → done at cycle 2, same values.
- `cancel_i` at cycle 10 → IDLE at cycle 11, `stall_o`=0 from cycle 11, no `done_o`, lo/hi unchanged. Back-to-back: second start right after DONE completes correctly.
- `rst` low at cycle 20 → all outputs 0 asynchronously. A start after reset release gives correct results.
